// File: rtl/host_port_arbiter_pkg.sv
// Shared definitions for the host port arbiter: default geometry, command kind
// and width helpers used by the top and the read tag FIFO.
package host_port_arbiter_pkg;

    localparam int ARB_NUM_REQ         = 4;
    localparam int ARB_ADDR_W          = 16;
    localparam int ARB_DATA_W          = 32;
    localparam int ARB_MAX_OUTSTANDING = 4;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_kind_e;

    // Requester id width; never narrower than one bit.
    function automatic int arb_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/host_port_arbiter_rd_tag_fifo.sv
// In-order FIFO of requester ids for reads in flight at the root node.
// Push and pop on the same edge are accepted even when full.
module host_port_arbiter_rd_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/host_port_arbiter.sv
// Shares the root node host command port between NUM_REQ requesters and steers
// read data back by tag. Define ARB_STRICT_PRIO_EN for fixed lowest-index priority.
module host_port_arbiter
    import host_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = ARB_NUM_REQ,
    parameter int ADDR_W          = ARB_ADDR_W,
    parameter int DATA_W          = ARB_DATA_W,
    parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_vld,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]          req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]          req_wdata,
    output logic [NUM_REQ-1:0]                 req_gnt,
    output logic [NUM_REQ-1:0]                 rsp_vld,
    output logic [DATA_W-1:0]                  rsp_data,
    input  logic [NUM_REQ-1:0]                 rsp_rdy,
    output logic                               write_en,
    input  logic                               write_rdy,
    output logic [ADDR_W-1:0]                  write_addr,
    output logic [DATA_W-1:0]                  write_data,
    output logic                               read_en,
    input  logic                               read_rdy,
    output logic [ADDR_W-1:0]                  read_addr,
    output logic                               read_data_rdy,
    input  logic                               read_data_vld,
    input  logic [DATA_W-1:0]                  read_data,
    output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);

    localparam int ID_W  = arb_id_w(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    typedef struct packed {
        cmd_kind_e         kind;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [ID_W-1:0]   id;
    } cmd_t;

    logic             cmd_vld_q, cmd_vld_d;
    cmd_t             cmd_q, cmd_d;
    logic             issue, rd_issue, can_load, read_room;
    logic [CNT_W:0]   reserved;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any, gnt_fire;
    logic [ID_W-1:0]  fifo_head;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign write_en   = cmd_vld_q & (cmd_q.kind == CMD_WRITE);
    assign read_en    = cmd_vld_q & (cmd_q.kind == CMD_READ);
    assign write_addr = cmd_q.addr;
    assign write_data = cmd_q.wdata;
    assign read_addr  = cmd_q.addr;

    assign rd_issue = read_en & read_rdy;
    assign issue    = (write_en & write_rdy) | rd_issue;
    assign can_load = ~cmd_vld_q | issue;

    // A read parked in the command register already owns a tag slot.
    assign reserved  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, read_en};
    assign read_room = ~fifo_full & (reserved < (CNT_W+1)'(MAX_OUTSTANDING));
    assign eligible  = req_vld & (req_we | {NUM_REQ{read_room}});

`ifndef ARB_STRICT_PRIO_EN
    logic [ID_W-1:0] ptr_q;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        req_gnt = '0;
`ifdef ARB_STRICT_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                gnt_id  = ID_W'(k);
                gnt_any = 1'b1;
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && eligible[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_id  = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                gnt_any = 1'b1;
            end
        end
`endif
        // Masked by rst_n so the grant vector reads 0 while reset is held.
        if (gnt_any && can_load && rst_n) begin
            req_gnt[gnt_id] = 1'b1;
        end
    end

    assign gnt_fire = |req_gnt;

    always_comb begin
        cmd_vld_d = cmd_vld_q;
        cmd_d     = cmd_q;
        if (issue) begin
            cmd_vld_d = 1'b0;
        end
        if (gnt_fire) begin
            cmd_vld_d   = 1'b1;
            cmd_d.kind  = req_we[gnt_id] ? CMD_WRITE : CMD_READ;
            cmd_d.addr  = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
            cmd_d.wdata = req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
            cmd_d.id    = gnt_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_vld_q <= 1'b0;
            cmd_q     <= '0;
        end else begin
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
        end
    end

`ifndef ARB_STRICT_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (gnt_fire) begin
            ptr_q <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end
    end
`endif

    host_port_arbiter_rd_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rd_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rd_issue),
        .push_data_i (cmd_q.id),
        .pop_i       (read_data_vld & read_data_rdy),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign read_data_rdy  = ~fifo_empty & rsp_rdy[fifo_head];
    assign rd_outstanding = fifo_count;
    assign rsp_data       = rst_n ? read_data : '0;

    always_comb begin
        rsp_vld = '0;
        if (!fifo_empty && read_data_vld) begin
            rsp_vld[fifo_head] = 1'b1;
        end
    end

endmodule
